// File: rtl/palette_fade_ctrl.sv
// Palette brightness fader: steps a 0..16 level on vsync frame ticks and
// scales the palette colour of each pixel by level/16 in a two-stage pipeline.
module palette_fade_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       vsync,
    input  logic       start_fade_in,
    input  logic       start_fade_out,
    input  logic [3:0] pix_index,
    input  logic       pix_valid,
    output logic [3:0] pal_index,
    input  logic [3:0] pal_red,
    input  logic [3:0] pal_green,
    input  logic [3:0] pal_blue,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       rgb_valid,
    output logic [4:0] level,
    output logic       busy,
    output logic       fade_done
);

    localparam int unsigned COL_W  = 4;
    localparam int unsigned LVL_W  = 5;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PROD_W = 9;

    typedef enum logic [1:0] {
        DARK     = 2'd0,
        FADE_IN  = 2'd1,
        BRIGHT   = 2'd2,
        FADE_OUT = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   step_cnt;
    logic [CNT_W-1:0]   step_cnt_nxt;
    logic [LVL_W-1:0]   level_nxt;
    logic               fade_done_nxt;
    logic               vsync_q;
    logic               valid_d1;
    logic               frame_tick_c;
    logic               step_due_c;
    logic [PROD_W-1:0]  prod_red_c;
    logic [PROD_W-1:0]  prod_green_c;
    logic [PROD_W-1:0]  prod_blue_c;

    assign frame_tick_c = vsync_q & ~vsync;
    assign step_due_c   = frame_tick_c &&
                          (CNT_W'(step_cnt + CNT_W'(1)) == CNT_W'(FRAMES_PER_STEP));

    // Next-state: start requests win over a coincident step; fade_out has priority
    always_comb begin
        state_nxt     = state;
        step_cnt_nxt  = step_cnt;
        level_nxt     = level;
        fade_done_nxt = 1'b0;
        case (state)
            DARK: begin
                if (start_fade_in && !start_fade_out) begin
                    state_nxt    = FADE_IN;
                    step_cnt_nxt = '0;
                end
            end
            FADE_IN: begin
                if (start_fade_out) begin
                    state_nxt    = FADE_OUT;
                    step_cnt_nxt = '0;
                end else if (step_due_c) begin
                    step_cnt_nxt = '0;
                    level_nxt    = level + LVL_W'(1);
                    if (level == LVL_W'(15)) begin
                        state_nxt     = BRIGHT;
                        fade_done_nxt = 1'b1;
                    end
                end else if (frame_tick_c) begin
                    step_cnt_nxt = step_cnt + CNT_W'(1);
                end
            end
            BRIGHT: begin
                if (start_fade_out) begin
                    state_nxt    = FADE_OUT;
                    step_cnt_nxt = '0;
                end
            end
            FADE_OUT: begin
                if (start_fade_in && !start_fade_out) begin
                    state_nxt    = FADE_IN;
                    step_cnt_nxt = '0;
                end else if (step_due_c) begin
                    step_cnt_nxt = '0;
                    level_nxt    = level - LVL_W'(1);
                    if (level == LVL_W'(1)) begin
                        state_nxt     = DARK;
                        fade_done_nxt = 1'b1;
                    end
                end else if (frame_tick_c) begin
                    step_cnt_nxt = step_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = DARK;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= DARK;
            step_cnt  <= '0;
            level     <= '0;
            vsync_q   <= 1'b1;
            busy      <= 1'b0;
            fade_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_cnt  <= step_cnt_nxt;
            level     <= level_nxt;
            vsync_q   <= vsync;
            busy      <= (state_nxt == FADE_IN) || (state_nxt == FADE_OUT);
            fade_done <= fade_done_nxt;
        end
    end

    // Stage 2 scales with the level currently held, so max product is 15*16
    assign prod_red_c   = PROD_W'(pal_red)   * PROD_W'(level);
    assign prod_green_c = PROD_W'(pal_green) * PROD_W'(level);
    assign prod_blue_c  = PROD_W'(pal_blue)  * PROD_W'(level);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pal_index <= '0;
            valid_d1  <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            rgb_valid <= 1'b0;
        end else begin
            pal_index <= pix_index;
            valid_d1  <= pix_valid;
            rgb_valid <= valid_d1;
            red       <= valid_d1 ? COL_W'(prod_red_c   >> 4) : '0;
            green     <= valid_d1 ? COL_W'(prod_green_c >> 4) : '0;
            blue      <= valid_d1 ? COL_W'(prod_blue_c  >> 4) : '0;
        end
    end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Bench for palette_fade_ctrl: directed fade scenarios followed by random
// traffic, all checked every cycle against a behavioural model.
module tb_palette_fade_ctrl;

    localparam int FPS = 2;
    localparam int P_DARK = 0, P_IN = 1, P_BRIGHT = 2, P_OUT = 3;

    logic       Clk = 1'b0;
    logic       Reset, vsync, start_fade_in, start_fade_out, pix_valid;
    logic [3:0] pix_index, pal_index, pal_red, pal_green, pal_blue;
    logic [3:0] red, green, blue;
    logic       rgb_valid, busy, fade_done;
    logic [4:0] level;

    logic [3:0] pal_r [16];
    logic [3:0] pal_g [16];
    logic [3:0] pal_b [16];

    int errors = 0;
    int checks = 0;

    // Model state
    int m_phase, m_level, m_frames, m_vs_prev, m_pidx, m_vd1;
    int e_red, e_green, e_blue, e_valid, e_done, e_busy;

    always #5 Clk = ~Clk;

    assign pal_red   = pal_r[pal_index];
    assign pal_green = pal_g[pal_index];
    assign pal_blue  = pal_b[pal_index];

    palette_fade_ctrl #(.FRAMES_PER_STEP(FPS)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .vsync         (vsync),
        .start_fade_in (start_fade_in),
        .start_fade_out(start_fade_out),
        .pix_index     (pix_index),
        .pix_valid     (pix_valid),
        .pal_index     (pal_index),
        .pal_red       (pal_red),
        .pal_green     (pal_green),
        .pal_blue      (pal_blue),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .rgb_valid     (rgb_valid),
        .level         (level),
        .busy          (busy),
        .fade_done     (fade_done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference evaluated once per rising edge
    task automatic model_update();
        bit tick;
        if (Reset) begin
            m_phase = P_DARK; m_level = 0; m_frames = 0; m_vs_prev = 1;
            m_pidx = 0; m_vd1 = 0;
            e_red = 0; e_green = 0; e_blue = 0; e_valid = 0; e_done = 0;
        end else begin
            e_red   = m_vd1 ? int'(pal_r[m_pidx]) * m_level / 16 : 0;
            e_green = m_vd1 ? int'(pal_g[m_pidx]) * m_level / 16 : 0;
            e_blue  = m_vd1 ? int'(pal_b[m_pidx]) * m_level / 16 : 0;
            e_valid = m_vd1;
            m_pidx  = int'(pix_index);
            m_vd1   = int'(pix_valid);
            tick    = (m_vs_prev == 1) && (vsync == 1'b0);
            m_vs_prev = int'(vsync);
            e_done  = 0;
            if (start_fade_out && (m_phase == P_IN || m_phase == P_BRIGHT)) begin
                m_phase = P_OUT; m_frames = 0;
            end else if (start_fade_in && !start_fade_out &&
                         (m_phase == P_DARK || m_phase == P_OUT)) begin
                m_phase = P_IN; m_frames = 0;
            end else if ((m_phase == P_IN || m_phase == P_OUT) && tick) begin
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0;
                    m_level += (m_phase == P_IN) ? 1 : -1;
                    if (m_level == 16) begin
                        m_phase = P_BRIGHT; e_done = 1;
                    end else if (m_level == 0) begin
                        m_phase = P_DARK; e_done = 1;
                    end
                end
            end
        end
        e_busy = (m_phase == P_IN || m_phase == P_OUT) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge Clk);
        model_update();
        #1;
        check_eq("level",     int'(level),     m_level);
        check_eq("busy",      int'(busy),      e_busy);
        check_eq("fade_done", int'(fade_done), e_done);
        check_eq("pal_index", int'(pal_index), m_pidx);
        check_eq("rgb_valid", int'(rgb_valid), e_valid);
        check_eq("red",       int'(red),       e_red);
        check_eq("green",     int'(green),     e_green);
        check_eq("blue",      int'(blue),      e_blue);
    endtask

    task automatic frame();
        pix_valid = 1'b1;
        pix_index = 4'($urandom_range(0, 15));
        vsync = 1'b0;
        step();
        pix_index = 4'($urandom_range(0, 15));
        vsync = 1'b1;
        step();
    endtask

    task automatic pulse_in();
        start_fade_in = 1'b1; step(); start_fade_in = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            pal_r[i] = 4'($urandom_range(0, 15));
            pal_g[i] = 4'($urandom_range(0, 15));
            pal_b[i] = 4'($urandom_range(0, 15));
        end
        pal_r[5] = 4'hB;
        pal_r[7] = 4'hF;
        Reset = 1'b1; vsync = 1'b1; start_fade_in = 1'b0; start_fade_out = 1'b0;
        pix_valid = 1'b1; pix_index = 4'd5;
        step();
        step();
        Reset = 1'b0;

        // Full fade-in over 32 frame ticks
        pulse_in();
        repeat (32) frame();
        pix_index = 4'd5;
        repeat (3) step();
        check_eq("bright_red_b", int'(red), 11);

        // Fade-in request while bright is ignored
        pulse_in();
        repeat (2) step();

        // Fade-in to level 6, then reverse
        Reset = 1'b1; step(); Reset = 1'b0;
        pulse_in();
        repeat (12) frame();
        check_eq("level6", int'(level), 6);
        start_fade_out = 1'b1; step(); start_fade_out = 1'b0;
        repeat (4) frame();

        // Both requests together while fading in
        pulse_in();
        repeat (2) frame();
        start_fade_in = 1'b1; start_fade_out = 1'b1; step();
        start_fade_in = 1'b0; start_fade_out = 1'b0;
        repeat (3) frame();

        // Reset in the middle of a fade, then invalid pixels
        Reset = 1'b1; step(); Reset = 1'b0;
        pix_valid = 1'b0;
        repeat (3) step();

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            Reset          = ($urandom_range(0, 599) == 0);
            vsync          = 1'($urandom_range(0, 1));
            start_fade_in  = ($urandom_range(0, 119) == 0);
            start_fade_out = !start_fade_in && ($urandom_range(0, 119) == 0);
            pix_valid      = ($urandom_range(0, 3) != 0);
            pix_index      = 4'($urandom_range(0, 15));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
